// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_buffer
// Purpose  : Circular trace buffer for CPU debug. After arm, qualified
//            multi-channel samples are written into a DEPTH-entry ring.
//            A sampled trigger is followed by POST_TRIG further samples,
//            after which the capture is frozen and can be read out
//            oldest-first with single-cycle latency.
// Ports    : clk        - single clock, rising edge
//            reset      - asynchronous, active-high
//            ch_data    - NCH channels, channel k at [k*WIDTH +: WIDTH]
//            sample_en  - ch_data is valid this cycle
//            arm        - start a capture (IDLE or DONE)
//            trig       - trigger event (sampled only in CAPTURE)
//            rd_req     - request the next oldest entry (DONE only)
//            rd_data    - readout entry (+16-bit timestamp when enabled)
//            rd_valid   - rd_data valid this cycle
//            state      - IDLE=0, CAPTURE=1, POST=2, DONE=3
//            count      - number of valid entries
// Options  : TRACE_TIMESTAMP_EN - when defined, a 16-bit sample-clock
//            counter is stored with every entry and returned in
//            rd_data[NCH*WIDTH +: 16].
// Revision : 1.0 - initial release
// ============================================================================
module cpu_trace_buffer #(
    parameter int WIDTH     = 32,
    parameter int NCH       = 2,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCH*WIDTH-1:0]       ch_data,
    input  logic                       sample_en,
    input  logic                       arm,
    input  logic                       trig,
    input  logic                       rd_req,
`ifdef TRACE_TIMESTAMP_EN
    output logic [NCH*WIDTH+16-1:0]    rd_data,
`else
    output logic [NCH*WIDTH-1:0]       rd_data,
`endif
    output logic                       rd_valid,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = NCH * WIDTH;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = DW + 16;
`else
    localparam int EW = DW;
`endif

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] POST    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] post_cnt;
    logic [CW-1:0] remaining;

    logic          wr_en;
    logic [EW-1:0] wr_entry;
    logic [AW-1:0] wr_next;
    logic [CW-1:0] cnt_next;
    logic [AW-1:0] oldest_next;
    logic          arm_accept;

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] timestamp;

    // Cleared whenever a capture starts, counts every cycle of an active capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timestamp <= '0;
        end else if (arm_accept) begin
            timestamp <= '0;
        end else if (state == CAPTURE || state == POST) begin
            timestamp <= timestamp + 16'd1;
        end
    end

    assign wr_entry = {timestamp, ch_data};
`else
    assign wr_entry = ch_data;
`endif

    assign arm_accept = arm && (state == IDLE || state == DONE);
    assign wr_en      = sample_en && (state == CAPTURE || state == POST);
    assign wr_next    = wr_ptr + 1'b1;
    assign cnt_next   = (count == CW'(DEPTH)) ? count : count + 1'b1;
    // Oldest entry once the current write lands; when the ring is full the
    // low bits of cnt_next are zero and the oldest is the next write slot.
    assign oldest_next = wr_next - cnt_next[AW-1:0];

    // Storage carries no reset; stale contents are never read because
    // remaining bounds every readout.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            remaining <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state  <= CAPTURE;
                        count  <= '0;
                        wr_ptr <= '0;
                    end
                end
                CAPTURE: begin
                    if (sample_en) begin
                        wr_ptr <= wr_next;
                        count  <= cnt_next;
                        if (trig) begin
                            if (POST_TRIG == 0) begin
                                state     <= DONE;
                                rd_ptr    <= oldest_next;
                                remaining <= cnt_next;
                            end else begin
                                state    <= POST;
                                post_cnt <= AW'(POST_TRIG);
                            end
                        end
                    end
                end
                POST: begin
                    if (sample_en) begin
                        wr_ptr   <= wr_next;
                        count    <= cnt_next;
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == AW'(1)) begin
                            state     <= DONE;
                            rd_ptr    <= oldest_next;
                            remaining <= cnt_next;
                        end
                    end
                end
                DONE: begin
                    if (arm) begin
                        // Restart discards whatever has not been read yet.
                        state     <= CAPTURE;
                        count     <= '0;
                        wr_ptr    <= '0;
                        remaining <= '0;
                    end else if (rd_req && remaining != '0) begin
                        rd_data   <= mem[rd_ptr];
                        rd_valid  <= 1'b1;
                        rd_ptr    <= rd_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == CW'(1)) begin
                            state <= IDLE;
                            count <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_trace_buffer
// Purpose  : Directed self-checking bench for cpu_trace_buffer with
//            WIDTH=32, NCH=2, DEPTH=16, POST_TRIG=8. Captured samples are
//            pushed into a bounded scoreboard queue and popped on readout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_buffer;

    localparam int WIDTH = 32;
    localparam int NCH   = 2;
    localparam int DEPTH = 16;
    localparam int DW    = NCH * WIDTH;
`ifdef TRACE_TIMESTAMP_EN
    localparam int RW = DW + 16;
`else
    localparam int RW = DW;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] ch_data;
    logic          sample_en;
    logic          arm;
    logic          trig;
    logic          rd_req;
    logic [RW-1:0] rd_data;
    logic          rd_valid;
    logic [1:0]    state;
    logic [4:0]    count;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb_q[$];

    cpu_trace_buffer #(
        .WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .POST_TRIG(8)
    ) dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .sample_en(sample_en),
        .arm(arm), .trig(trig), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .state(state), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One qualified sample {~i, i}; captured ones enter the 16-deep model.
    task automatic put(input int i, input logic t, input logic captured);
        logic [31:0] v;
        v = 32'(i);
        ch_data   = {~v, v};
        sample_en = 1'b1;
        trig      = t;
        if (captured) begin
            sb_q.push_back({~v, v});
            if (sb_q.size() > DEPTH) void'(sb_q.pop_front());
        end
        tick();
        sample_en = 1'b0;
        trig      = 1'b0;
    endtask

    task automatic do_arm();
        sb_q.delete();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic read_all(input string tag, input int n);
        logic [63:0] exp;
        rd_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hDEAD;
            check({tag, "_valid"}, 64'(rd_valid), 64'd1);
            check({tag, "_data"}, rd_data[63:0], exp);
        end
        rd_req = 1'b0;
    endtask

    task automatic extra_read(input string tag);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check(tag, 64'(rd_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; ch_data = '0; sample_en = 1'b0; arm = 1'b0;
        trig = 1'b0; rd_req = 1'b0;
        tick(); tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_data", rd_data[63:0], 64'd0);
        reset = 1'b0;
        tick();

        extra_read("idle_rdreq");

        // Wrap-around capture: trigger at 20, last captured sample is 28.
        do_arm();
        check("arm_state", 64'(state), 64'd1);
        check("arm_count", 64'(count), 64'd0);
        for (int i = 0; i < 30; i++) begin
            put(i, i == 20, i <= 28);
            if (i == 20) check("wrap_post", 64'(state), 64'd2);
            if (i == 27) check("wrap_pre_done", 64'(state), 64'd2);
            if (i == 28) check("wrap_done", 64'(state), 64'd3);
        end
        check("wrap_count", 64'(count), 64'd16);
        check("wrap_qsize", 64'(sb_q.size()), 64'd16);
        check("wrap_first", sb_q[0], {~32'd13, 32'd13});
        read_all("wrap_rd", 16);
        check("wrap_end_state", 64'(state), 64'd0);
        check("wrap_end_count", 64'(count), 64'd0);
        extra_read("wrap_extra");

        // Short capture: trigger at 3, twelve entries, no wrap.
        do_arm();
        for (int i = 0; i < 12; i++) put(i, i == 3, 1'b1);
        check("short_state", 64'(state), 64'd3);
        check("short_count", 64'(count), 64'd12);
        read_all("short_rd", 12);
        extra_read("short_13th");

        // Gaps during POST delay DONE without losing or duplicating samples.
        do_arm();
        for (int i = 0; i < 6; i++) put(i, i == 2, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        check("gap_still_post", 64'(state), 64'd2);
        check("gap_count", 64'(count), 64'd6);
        for (int i = 6; i < 10; i++) put(i, 1'b0, 1'b1);
        check("gap_pre_done", 64'(state), 64'd2);
        put(10, 1'b0, 1'b1);
        check("gap_done", 64'(state), 64'd3);
        check("gap_count_done", 64'(count), 64'd11);
        read_all("gap_rd", 11);

        // Reset asserted between clock edges during POST.
        do_arm();
        for (int i = 0; i < 4; i++) put(i, i == 1, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_state", 64'(state), 64'd0);
        check("async_count", 64'(count), 64'd0);
        check("async_valid", 64'(rd_valid), 64'd0);
        #1 reset = 1'b0;
        tick();
        do_arm();
        for (int i = 100; i < 109; i++) put(i, i == 100, 1'b1);
        check("fresh_state", 64'(state), 64'd3);
        check("fresh_count", 64'(count), 64'd9);
        read_all("fresh_rd", 9);

        // arm with trig in IDLE: trig dropped, CAPTURE held until a real trigger.
        arm = 1'b1; trig = 1'b1; sb_q.delete();
        tick();
        arm = 1'b0; trig = 1'b0;
        check("armtrig_state", 64'(state), 64'd1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("trig_no_sample", 64'(state), 64'd1);
        for (int i = 0; i < 3; i++) put(i, 1'b0, 1'b1);
        check("armtrig_hold", 64'(state), 64'd1);
        put(3, 1'b1, 1'b1);
        check("armtrig_post", 64'(state), 64'd2);
        for (int i = 4; i < 12; i++) put(i, 1'b0, 1'b1);
        check("armtrig_done", 64'(state), 64'd3);

        // arm in DONE discards unread entries.
        read_all("partial_rd", 2);
        do_arm();
        check("rearm_state", 64'(state), 64'd1);
        check("rearm_count", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
